// File: rtl/row_scan_ctrl.sv
// Row-select scan controller driving a 4-to-16 decoder; all outputs registered.
// Optional macro ROW_SCAN_BLANK_EN inserts one blanking cycle per row advance.
module row_scan_ctrl #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         last_row,
    output logic [3:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef ROW_SCAN_BLANK_EN
        S_BLANK,
`endif
        S_SCAN
    } state_t;

    localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_nx;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nx;
    logic [DWELL_W-1:0] r_dwell_q, w_dwell_nx;
    logic [3:0]         r_last_q, w_last_nx;
    logic               r_stop_pend, w_pend_nx;
    logic [3:0]         r_sel, w_sel_nx;
    logic               r_sel_valid, w_valid_nx;
    logic               r_busy, w_busy_nx;
    logic               r_frame_done, w_fd_nx;

    logic [DWELL_W-1:0] w_dwell_in;
    logic [DWELL_W-1:0] w_reload;
    logic               w_is_last;
    logic [3:0]         w_next_row;

    assign w_dwell_in = (dwell == '0) ? ONE : dwell;
    assign w_reload   = r_dwell_q - ONE;
    assign w_is_last  = (r_sel == r_last_q);
    assign w_next_row = r_sel + 4'd1;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dwell_nx = r_dwell_q;
        w_last_nx  = r_last_q;
        w_pend_nx  = r_stop_pend;
        w_sel_nx   = r_sel;
        w_valid_nx = r_sel_valid;
        w_busy_nx  = r_busy;
        w_fd_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dwell_nx = w_dwell_in;
                    w_last_nx  = last_row;
                    w_cnt_nx   = w_dwell_in - ONE;
                    w_pend_nx  = 1'b0;
                    w_sel_nx   = 4'd0;
                    w_valid_nx = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_SCAN;
                end
            end
            S_SCAN: begin
                if (stop) w_pend_nx = 1'b1;
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - ONE;
                end else if (w_is_last && (r_stop_pend || stop)) begin
                    // Stopping at frame end skips the blank even when enabled
                    w_fd_nx    = 1'b1;
                    w_pend_nx  = 1'b0;
                    w_sel_nx   = 4'd0;
                    w_valid_nx = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_fd_nx = w_is_last;
`ifdef ROW_SCAN_BLANK_EN
                    w_valid_nx = 1'b0;
                    w_state_nx = S_BLANK;
`else
                    w_sel_nx = w_is_last ? 4'd0 : w_next_row;
                    w_cnt_nx = w_reload;
`endif
                end
            end
`ifdef ROW_SCAN_BLANK_EN
            S_BLANK: begin
                w_sel_nx   = w_is_last ? 4'd0 : w_next_row;
                w_cnt_nx   = w_reload;
                w_valid_nx = 1'b1;
                w_state_nx = S_SCAN;
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dwell_q    <= '0;
            r_last_q     <= '0;
            r_stop_pend  <= 1'b0;
            r_sel        <= '0;
            r_sel_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_dwell_q    <= w_dwell_nx;
            r_last_q     <= w_last_nx;
            r_stop_pend  <= w_pend_nx;
            r_sel        <= w_sel_nx;
            r_sel_valid  <= w_valid_nx;
            r_busy       <= w_busy_nx;
            r_frame_done <= w_fd_nx;
        end
    end

    assign sel        = r_sel;
    assign sel_valid  = r_sel_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
